// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: port ids, FSM encoding
// and the read-return tag that follows each access through the memory latency.
package mem_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  localparam logic [0:0] ST_ARB     = 1'b0;
  localparam logic [0:0] ST_LOCK_LD = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rd_return_pipe.sv
// Delay line of {valid, id} tags matching the memory read latency, so each
// returning word can be steered to the port that issued the read.
module rd_return_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_push_valid,
  input  logic i_push_id,
  output logic o_pop_valid,
  output logic o_pop_id
);

  rd_tag_t r_pipe [RD_LAT];

  // NOTE: the tags must be cleared on reset so reads in flight are dropped.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      // NOTE: non-blocking, so every stage takes its predecessor's old value.
      r_pipe[0] <= '{valid: i_push_valid, id: i_push_id};
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_pop_valid = r_pipe[RD_LAT-1].valid;
  assign o_pop_id    = r_pipe[RD_LAT-1].id;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between the core (port 0) and the
// debug/program loader (port 1): round-robin, loader lock, starvation bound.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic          ld_lock,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic           r_last;
  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic           w_force;
  logic           w_cpu_gnt;
  logic           w_ld_gnt;
  logic           w_pop_valid;
  logic           w_pop_id;

  // A core that has waited MAX_WAIT cycles wins regardless of lock or turn.
  assign w_force = rstb & cpu_req & (r_wait_cnt == WCW'(MAX_WAIT));

  // NOTE: defaults first so no path leaves a grant unassigned (no latches).
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ld_gnt  = 1'b0;
    if (rstb) begin
      if (w_force) begin
        w_cpu_gnt = 1'b1;
      end else if (r_state == ST_LOCK_LD) begin
        w_ld_gnt = ld_req;
      end else if (cpu_req && ld_req) begin
        w_cpu_gnt = (r_last == PORT_LD);
        w_ld_gnt  = (r_last == PORT_CPU);
      end else begin
        w_cpu_gnt = cpu_req;
        w_ld_gnt  = ld_req;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_ARB) begin
      if (w_ld_gnt && ld_lock) w_state_nxt = ST_LOCK_LD;
    end else if (!ld_lock) begin
      w_state_nxt = ST_ARB;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state    <= ST_ARB;
      r_last     <= PORT_LD;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cpu_gnt)     r_last <= PORT_CPU;
      else if (w_ld_gnt) r_last <= PORT_LD;
      if (!cpu_req || w_cpu_gnt)              r_wait_cnt <= '0;
      else if (r_wait_cnt != WCW'(MAX_WAIT))  r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign ld_gnt    = w_ld_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;
  assign mem_en    = w_cpu_gnt | w_ld_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  rd_return_pipe #(.RD_LAT(RD_LAT)) u_rd_return_pipe (
    .clk          (clk),
    .rstb         (rstb),
    .i_push_valid (mem_en & ~mem_we),
    .i_push_id    (w_ld_gnt),
    .o_pop_valid  (w_pop_valid),
    .o_pop_id     (w_pop_id)
  );

  assign cpu_rvalid = rstb & w_pop_valid & (w_pop_id == PORT_CPU);
  assign ld_rvalid  = rstb & w_pop_valid & (w_pop_id == PORT_LD);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ld_rdata   = ld_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances share stimulus; instance 0 is the
// default build, 1 has MAX_WAIT=3, 2 has RD_LAT=3. Each has its own memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        cpu_req, cpu_we, ld_req, ld_we, ld_lock;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;

  logic        cpu_gnt [3], cpu_stall [3], cpu_rvalid [3];
  logic        ld_gnt [3], ld_rvalid [3], mem_en [3], mem_we [3];
  logic [31:0] cpu_rdata [3], ld_rdata [3], mem_addr [3], mem_wdata [3];
  logic [31:0] mem_rdata [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int MW  = (g == 1) ? 3 : 8;

    logic [31:0] store [0:255];
    logic [31:0] pipe  [0:3];

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT), .MAX_WAIT(MW)) u_dut (
      .clk        (clk),
      .rstb       (rstb),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt[g]),
      .cpu_stall  (cpu_stall[g]),
      .cpu_rvalid (cpu_rvalid[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .ld_req     (ld_req),
      .ld_we      (ld_we),
      .ld_lock    (ld_lock),
      .ld_addr    (ld_addr),
      .ld_wdata   (ld_wdata),
      .ld_gnt     (ld_gnt[g]),
      .ld_rvalid  (ld_rvalid[g]),
      .ld_rdata   (ld_rdata[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) store[i] <= 32'hA000_0000 + 32'(i);
      store[4] <= 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end

    // Synchronous-read memory; returns data LAT cycles after the address.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) store[mem_addr[g][9:2]] <= mem_wdata[g];
      pipe[0] <= store[mem_addr[g][9:2]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    ld_req  = 1'b0;
    ld_we   = 1'b0;
    ld_lock = 1'b0;
  endtask

  initial begin
    rstb      = 1'b0;
    idle();
    cpu_addr  = 32'h20;
    ld_addr   = 32'h30;
    cpu_wdata = 32'h5555;
    ld_wdata  = 32'hAAAA;

    // Reset: requests present but everything must read 0.
    cpu_req = 1'b1;
    cpu_we  = 1'b1;
    ld_req  = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_cpu_gnt",   cpu_gnt[0],   0);
    chk("rst_ld_gnt",    ld_gnt[0],    0);
    chk("rst_mem_en",    mem_en[0],    0);
    chk("rst_mem_addr",  mem_addr[0],  0);
    chk("rst_mem_wdata", mem_wdata[0], 0);
    chk("rst_cpu_rv",    cpu_rvalid[0], 0);
    cyc();
    rstb = 1'b1;
    idle();

    // Tie after reset: cpu, ld, cpu, ld; data returns one cycle later.
    cpu_req = 1'b1;
    ld_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tie_cpu_gnt", cpu_gnt[0], (i % 2 == 0));
      chk("tie_ld_gnt",  ld_gnt[0],  (i % 2 == 1));
      if (i % 2 == 1) chk("tie_cpu_stall", cpu_stall[0], 1);
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          chk("tie_cpu_rv",    cpu_rvalid[0], 1);
          chk("tie_cpu_rdata", cpu_rdata[0],  32'hA000_0008);
          chk("tie_ld_rv0",    ld_rvalid[0],  0);
        end else begin
          chk("tie_ld_rv",     ld_rvalid[0],  1);
          chk("tie_ld_rdata",  ld_rdata[0],   32'hA000_000C);
          chk("tie_cpu_rdata0", cpu_rdata[0], 0);
        end
      end
      cyc();
    end
    idle();
    @(negedge clk);
    chk("tie_ld_rv_last",   ld_rvalid[0],  1);
    chk("tie_ld_rd_last",   ld_rdata[0],   32'hA000_000C);
    chk("tie_cpu_rv_last",  cpu_rvalid[0], 0);
    cyc();

    // Single-port core read.
    cpu_req  = 1'b1;
    cpu_addr = 32'h10;
    @(negedge clk);
    chk("rd_cpu_gnt",   cpu_gnt[0],   1);
    chk("rd_cpu_stall", cpu_stall[0], 0);
    chk("rd_mem_en",    mem_en[0],    1);
    chk("rd_mem_addr",  mem_addr[0],  32'h10);
    chk("rd_mem_we",    mem_we[0],    0);
    cyc();
    idle();
    @(negedge clk);
    chk("rd_cpu_rv",    cpu_rvalid[0], 1);
    chk("rd_cpu_rdata", cpu_rdata[0],  32'hDEAD_BEEF);
    chk("rd_ld_rv",     ld_rvalid[0],  0);
    chk("rd_ld_rdata",  ld_rdata[0],   0);
    cyc();

    // Loader lock: 5 locked grants, then lock released with no loader request.
    for (int i = 0; i < 5; i++) begin
      cpu_req = 1'b1;
      ld_req  = 1'b1;
      ld_lock = 1'b1;
      @(negedge clk);
      chk("lock_ld_gnt",    ld_gnt[0],    1);
      chk("lock_cpu_stall", cpu_stall[0], 1);
      cyc();
    end
    ld_req  = 1'b0;
    ld_lock = 1'b0;
    @(negedge clk);
    chk("lock_rel_cpu_gnt", cpu_gnt[0], 0);
    chk("lock_rel_ld_gnt",  ld_gnt[0],  0);
    cyc();
    @(negedge clk);
    chk("lock_after_cpu_gnt", cpu_gnt[0], 1);
    cyc();
    idle();

    // Fresh reset, then starvation bound on instance 1 (MAX_WAIT=3).
    rstb = 1'b0;
    cyc();
    rstb = 1'b1;
    ld_req  = 1'b1;
    ld_lock = 1'b1;
    @(negedge clk);
    chk("starve_lock_gnt", ld_gnt[1], 1);
    cyc();
    cpu_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("starve_forced_cpu", cpu_gnt[1], 1);
        chk("starve_forced_ld",  ld_gnt[1],  0);
        chk("starve_mw8_ld",     ld_gnt[0],  1);
      end else begin
        chk("starve_ld_gnt",  ld_gnt[1],  1);
        chk("starve_cpu_gnt", cpu_gnt[1], 0);
      end
      cyc();
    end
    idle();
    cyc();

    // Loader write, then core read of the same address.
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 32'h0040_0000;
    ld_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr_ld_gnt",    ld_gnt[0],    1);
    chk("wr_mem_we",    mem_we[0],    1);
    chk("wr_mem_addr",  mem_addr[0],  32'h0040_0000);
    chk("wr_mem_wdata", mem_wdata[0], 32'h1234_5678);
    cyc();
    ld_req   = 1'b0;
    ld_we    = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 32'h0040_0000;
    @(negedge clk);
    chk("wr_rd_cpu_gnt", cpu_gnt[0],   1);
    chk("wr_rd_mem_we",  mem_we[0],    0);
    chk("wr_no_ld_rv",   ld_rvalid[0], 0);
    cyc();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("wr_rd_cpu_rv",    cpu_rvalid[0], 1);
    chk("wr_rd_cpu_rdata", cpu_rdata[0],  32'h1234_5678);
    chk("wr_idle_wdata",   mem_wdata[0],  0);
    chk("wr_idle_addr",    mem_addr[0],   0);
    cyc();

    // Reset with a read in flight on instance 2 (RD_LAT=3).
    cpu_req  = 1'b1;
    cpu_addr = 32'h10;
    @(negedge clk);
    chk("mid_cpu_gnt", cpu_gnt[2], 1);
    cyc();
    cpu_req = 1'b0;
    rstb    = 1'b0;
    @(negedge clk);
    chk("mid_rst_cpu_rv", cpu_rvalid[2], 0);
    cyc();
    rstb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_cpu_rv", cpu_rvalid[2], 0);
      chk("mid_no_ld_rv",  ld_rvalid[2],  0);
      cyc();
    end

    // Fresh state after reset: tie goes to the core; RD_LAT=3 return order.
    cpu_req = 1'b1;
    ld_req  = 1'b1;
    @(negedge clk);
    chk("post_tie_cpu_gnt", cpu_gnt[2], 1);
    chk("post_tie_ld_gnt",  ld_gnt[2],  0);
    cyc();
    @(negedge clk);
    chk("post_tie_ld_gnt2", ld_gnt[2], 1);
    cyc();
    idle();
    @(negedge clk);
    chk("lat3_cpu_rv_early", cpu_rvalid[2], 0);
    cyc();
    @(negedge clk);
    chk("lat3_cpu_rv",    cpu_rvalid[2], 1);
    chk("lat3_cpu_rdata", cpu_rdata[2],  32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    chk("lat3_ld_rv",    ld_rvalid[2], 1);
    chk("lat3_ld_rdata", ld_rdata[2],  32'h1234_5678);
    chk("lat3_cpu_rv0",  cpu_rvalid[2], 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: port 0 is the mips core (fetch and load/store) and port 1 is the debug/program loader.
- Arbitration is round-robin, with an optional loader burst lock and a starvation bound.
- Read data returns in order after a fixed memory latency and is steered back to the requester that issued the read.
- Sits between the core's mem_addr/mem_wr_data/mem_wr_ena outputs and the synchronous-read memory; cpu_stall freezes the core while it is not granted.

Parameters:
- AW, 32, address width
- DW, 32, data width
- RD_LAT, 1, memory read latency in cycles (mem_en with mem_we=0 -> mem_rdata valid RD_LAT cycles later); legal range 1..4
- MAX_WAIT, 8, maximum consecutive cycles the core may be refused while requesting before it is forced a grant

Ports:
- clk  in  1  clock
- rstb  in  1  reset, synchronous, active-low
- cpu_req  in  1  core requests an access this cycle
- cpu_we  in  1  core access is a write
- cpu_addr  in  AW  core address
- cpu_wdata  in  DW  core write data
- cpu_gnt  out  1  core access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  core read data valid
- cpu_rdata  out  DW  core read data
- ld_req  in  1  loader requests an access this cycle
- ld_we  in  1  loader access is a write
- ld_lock  in  1  loader asks to keep ownership after its next grant
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write data
- ld_gnt  out  1  loader access accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DW  loader read data
- mem_en  out  1  access issued to memory
- mem_we  out  1  write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Handshake: a request is accepted in the cycle req=1 and gnt=1. gnt is combinational from req and registered state. At most one gnt per cycle.
- mem_en = cpu_gnt | ld_gnt. mem_we/mem_addr/mem_wdata are muxed combinationally from the granted port; they are 0 when mem_en=0.
- Registered state:
  - last: owner of the previous grant, 0=cpu, 1=ld
  - fsm: ARB or LOCK_LD
  - wait_cnt: width clog2(MAX_WAIT+1), saturating
  - return pipe: RD_LAT stages of {valid, id}
- FSM in ARB:
  - Only one port requesting: that port is granted.
  - Both requesting: the port != last is granted.
  - ld granted with ld_lock=1 -> next state LOCK_LD.
- FSM in LOCK_LD:
  - Only ld is granted while ld_req=1; idle cycles are allowed.
  - ld_lock=0 at any cycle -> ARB next cycle; that cycle's arbitration still follows lock rules.
- Starvation bound:
  - wait_cnt increments each cycle cpu_req=1 and cpu_gnt=0; it clears on cpu_gnt or cpu_req=0.
  - wait_cnt==MAX_WAIT forces cpu_gnt=1 in that cycle, overriding lock and round-robin.
  - After a forced grant the FSM returns to LOCK_LD if ld_lock is still 1.
- last updates on every grant. Its reset value is 1, so the core wins the first tie.
- Read return:
  - Each read grant pushes {1,id} into stage 0. Writes and idle cycles push {0,x}.
  - At the final stage: valid with id=0 -> cpu_rvalid=1, cpu_rdata=mem_rdata. id=1 -> ld_rvalid/ld_rdata likewise.
  - Exactly one rvalid per accepted read, in issue order, exactly RD_LAT cycles after gnt. Back-to-back reads from alternating ports return interleaved in the same order.
  - rdata of the non-valid port is 0.
- Reset (rstb=0 at a clk edge):
  - fsm=ARB, last=1, wait_cnt=0, all pipe valids cleared.
  - All gnt/rvalid/rdata and mem_* outputs read 0 while rstb=0, regardless of req.
  - In-flight reads are dropped: no rvalid appears after reset, even if memory returns data.
- Simultaneous events:
  - Write and read to the same address in consecutive cycles are ordered by grant order; no forwarding is done.
  - ld_req=0 in LOCK_LD with cpu_req=1: the core is not granted (the lock holds) unless the starvation bound is reached.

Decomposition:
- Shared package mem_arb_pkg:
  - port id constants (PORT_CPU=0, PORT_LD=1)
  - fsm state encoding (ARB, LOCK_LD)
  - return-pipe entry typedef {valid, id}
- One natural sub-module: rd_return_pipe (parameterised RD_LAT shift register of {valid, id}, synchronous clear on rstb).

Test Plan:
- Single-port reads: cpu reads addr 0x10 (mem holds 0xDEADBEEF), RD_LAT=1 -> cpu_gnt same cycle, cpu_rvalid one cycle later with 0xDEADBEEF; ld_rvalid stays 0.
- Tie after reset: both req read, cycles 0..3 -> grants cpu, ld, cpu, ld; rvalids return in that order with the matching data.
- Lock: ld_lock=1 with ld_req=1 for 5 cycles, cpu_req=1, MAX_WAIT=8 -> ld granted 5 cycles, cpu_stall=1. ld_lock drops at cycle 5 -> cpu granted at cycle 6.
- Starvation: MAX_WAIT=3, ld locked with continuous req -> cpu_gnt forced on the 4th waiting cycle; ld regains grant the next cycle.
- Write path: ld write 0x00400000 <= 0x12345678, then cpu read of the same address -> mem_we=1 only on the ld grant; cpu_rdata=0x12345678; no rvalid for the write.
- Reset mid-read: RD_LAT=3, cpu read granted, rstb=0 one cycle later -> no cpu_rvalid ever. After release, state is fresh: a tie grants cpu first.
